// File: rtl/pm_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues 1-cycle registered reads to
// program memory, buffers returns in a 2-entry FWFT FIFO and streams them to the core.
module pm_fetch_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned MEM_SIZE   = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_pc,
   input  logic                  halt,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  cfg_write_busy,
   output logic [ADDR_WIDTH-1:0] pm_addr,
   output logic                  pm_read_en,
   input  logic [DATA_WIDTH-1:0] pm_read_data,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  busy,
   output logic                  pc_err
);

   localparam logic [ADDR_WIDTH:0]   LP_SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_iss_pc;
   logic                  r_pend;
   logic                  r_kill;
   logic                  r_pc_err;
   logic [DATA_WIDTH-1:0] r_data [2];
   logic [ADDR_WIDTH-1:0] r_fpc  [2];
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [1:0]            r_count;

   logic                  w_start_bad;
   logic                  w_redir_bad;
   logic                  w_start_ok;
   logic                  w_redir_act;
   logic                  w_redir_ok;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_pend_eff;
   logic [2:0]            w_occ;
   logic                  w_issue;
   logic                  w_pc_err_nx;

   always_comb begin
      w_state_nx  = r_state;
      w_start_bad = ({1'b0, start_pc} >= LP_SIZE);
      w_redir_bad = ({1'b0, redirect_pc} >= LP_SIZE);
      w_start_ok  = (r_state == ST_IDLE) & start & ~w_start_bad;
      // halt outranks redirect, so a redirect alongside halt is dropped silently
      w_redir_act = (r_state == ST_RUN) & ~halt & redirect_valid;
      w_redir_ok  = w_redir_act & ~w_redir_bad;
      w_pop       = instr_valid & instr_ready;
      // a killed in-flight word will never occupy the FIFO, so it does not hold back issue
      w_pend_eff  = r_pend & ~r_kill;
      w_occ       = {1'b0, r_count} + {2'b00, w_pend_eff} - {2'b00, w_pop};
      w_issue     = (r_state == ST_RUN) & ~halt & ~cfg_write_busy & (w_occ < 3'd2);
      w_push      = w_pend_eff & ~w_redir_ok;
      w_pc_err_nx = ((r_state == ST_IDLE) & start & w_start_bad) | (w_redir_act & w_redir_bad);

      unique case (r_state)
         ST_IDLE:  if (w_start_ok) w_state_nx = ST_RUN;
         ST_RUN:   if (halt)       w_state_nx = ST_DRAIN;
         ST_DRAIN: if (!r_pend)    w_state_nx = ST_IDLE;
         default:                  w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_pc     <= '0;
         r_iss_pc <= '0;
         r_pend   <= 1'b0;
         r_kill   <= 1'b0;
         r_pc_err <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            r_data[i] <= '0;
            r_fpc[i]  <= '0;
         end
      end else begin
         r_state  <= w_state_nx;
         r_pc_err <= w_pc_err_nx;
         r_pend   <= w_issue;
         // a read issued on the redirect edge targets the old PC; mark it for discard
         r_kill   <= w_redir_ok & w_issue;

         if (w_start_ok) begin
            r_pc <= start_pc;
         end else if (w_redir_ok) begin
            r_pc <= redirect_pc;
         end else if (w_issue) begin
            r_pc <= (r_pc == LP_LAST) ? '0 : r_pc + 1'b1;
         end

         if (w_issue) r_iss_pc <= r_pc;

         if (w_redir_ok) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_data[r_wr_ptr] <= pm_read_data;
               r_fpc[r_wr_ptr]  <= r_iss_pc;
               r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         end
      end
   end

   assign pm_addr     = r_pc;
   assign pm_read_en  = w_issue;
   assign instr_valid = (r_count != 2'd0);
   assign instr_data  = r_data[r_rd_ptr];
   assign instr_pc    = r_fpc[r_rd_ptr];
   assign busy        = (r_state != ST_IDLE) | (r_count != 2'd0);
   assign pc_err      = r_pc_err;

endmodule
